wb_host: RTL and testbench

// Wishbone B4 pipelined initiator (bus master), the counterpart to the

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_host_timeout.sv | 27 ++
 rtl/wb_host.sv | 148 ++++++++++++++
 tb/tb_wb_host.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: transaction state encodings and default bus widths,
// intended for reuse by other initiators and slaves on the same bus.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 16;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESPOND  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog for wb_host: a 16-bit counter that is cleared when a command is
// accepted, counts cycles while enabled, and flags expiry at LIMIT-1.
module wb_host_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [15:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = i_en && (r_count == 16'(LIMIT - 1));

endmodule

// File: rtl/wb_host.sv
// Wishbone B4 pipelined initiator running one classic cycle per request.
// Optional bus watchdog is enabled by defining WB_HOST_TIMEOUT_EN.
module wb_host
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W         = WB_ADDR_W,
  parameter int unsigned DATA_W         = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack
);

  wb_state_e         r_state, w_state_next;
  logic              r_cyc, w_cyc_next;
  logic              r_stb, w_stb_next;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic              r_rsp_valid, w_rsp_valid_next;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_next;
  logic              r_rsp_err, w_rsp_err_next;

  logic w_accept;
  logic w_slave_take;
  logic w_expired;

  assign w_accept     = i_req_valid && (r_state == ST_IDLE);
  assign w_slave_take = (r_state == ST_STROBE) && !i_wb_stall;

`ifdef WB_HOST_TIMEOUT_EN
  wb_host_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_wb_clk),
    .i_rst_n   (i_wb_rst_n),
    .i_clear   (w_accept),
    .i_en      (r_cyc),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cyc       <= w_cyc_next;
      r_stb       <= w_stb_next;
      r_we        <= w_we_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_err   <= w_rsp_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cyc_next       = r_cyc;
    w_stb_next       = r_stb;
    w_we_next        = r_we;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_err_next   = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_STROBE;
          w_cyc_next   = 1'b1;
          w_stb_next   = 1'b1;
          w_we_next    = i_req_we;
          w_addr_next  = i_req_addr;
          w_wdata_next = i_req_data;
        end
      end
      ST_STROBE, ST_WAIT_ACK: begin
        // A real ACK (not one raised while stalled) beats a same-edge timeout.
        if ((w_slave_take || r_state == ST_WAIT_ACK) && i_wb_ack) begin
          w_state_next     = ST_RESPOND;
          w_cyc_next       = 1'b0;
          w_stb_next       = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_data_next  = r_we ? '0 : i_wb_data;
          w_rsp_err_next   = 1'b0;
        end else if (w_expired) begin
          w_state_next     = ST_RESPOND;
          w_cyc_next       = 1'b0;
          w_stb_next       = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_data_next  = '0;
          w_rsp_err_next   = 1'b1;
        end else if (w_slave_take) begin
          w_state_next = ST_WAIT_ACK;
          w_stb_next   = 1'b0;
        end
      end
      ST_RESPOND: begin
        if (i_rsp_ready) begin
          w_state_next     = ST_IDLE;
          w_rsp_valid_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_wdata;

endmodule

// File: tb/tb_wb_host.sv
// Self-checking bench for wb_host: a table of single transactions against a scripted
// slave, plus hand-written back-to-back, reset-abort and (WB_HOST_TIMEOUT_EN) timeout cases.
module tb_wb_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata = '0;
  logic        wb_stall = 1'b0;
  logic        wb_ack = 1'b0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_host #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_wb_clk    (clk),
    .i_wb_rst_n  (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_addr   (wb_addr),
    .o_wb_data   (wb_wdata),
    .i_wb_data   (wb_rdata),
    .i_wb_stall  (wb_stall),
    .i_wb_ack    (wb_ack)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int unsigned stall;    // cycles STALL is held from STB rise
    int unsigned ack_dly;  // ACK this many cycles after the acceptance cycle
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int unsigned exp_stb;
    int unsigned exp_cyc;
    int unsigned hold;     // cycles rsp_ready stays low while valid
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int unsigned stb_n = 0;
    int unsigned cyc_n = 0;
    logic stable = 1'b1;
    logic ready_lo = 1'b1;
    logic done = 1'b0;
    check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
    req_we = v.we;
    req_addr = v.addr;
    req_data = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = ~v.we;
    req_addr = ~v.addr;
    req_data = ~v.wdata;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (wb_stb) stb_n++;
        if (wb_cyc) cyc_n++;
        if (wb_cyc && (wb_addr !== v.addr || wb_we !== v.we || wb_wdata !== v.wdata)) stable = 1'b0;
        if (req_ready) ready_lo = 1'b0;
        wb_stall = (c <= int'(v.stall));
        wb_ack   = (c == int'(v.stall + 1 + v.ack_dly));
        wb_rdata = wb_ack ? v.rdata : 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
      end
    end
    wb_stall = 1'b0;
    wb_ack = 1'b0;
    wb_rdata = 32'hBAD0_BAD0;
    check({tag, "_rsp_seen"}, 64'(done), 64'd1);
    check({tag, "_stb_cycles"}, 64'(stb_n), 64'(v.exp_stb));
    check({tag, "_cyc_cycles"}, 64'(cyc_n), 64'(v.exp_cyc));
    check({tag, "_bus_stable"}, 64'(stable), 64'd1);
    check({tag, "_ready_busy"}, 64'(ready_lo), 64'd1);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    check({tag, "_cyc_low"}, 64'(wb_cyc), 64'd0);
    for (int h = 0; h < int'(v.hold); h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(rsp_data), 64'(v.exp_data));
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, 64'(rsp_valid), 64'd0);
    check({tag, "_back_idle"}, 64'(req_ready), 64'd1);
  endtask

  vec_t vecs[5];

  initial begin
    //           we    addr      wdata          stall ack rdata          exp_data       err stb cyc hold
    vecs[0] = '{1'b1, 16'h0000, 32'h00FF_8040, 0, 2, 32'h1234_5678, 32'h0000_0000, 1'b0, 1, 3, 0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0000_0000, 3, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 5, 0};
    vecs[2] = '{1'b0, 16'h0020, 32'h1111_2222, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 1, 5};
    vecs[3] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 2, 0, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 3, 3, 1};
    vecs[4] = '{1'b0, 16'h8001, 32'h0F0F_0F0F, 1, 3, 32'h0000_0001, 32'h0000_0001, 1'b0, 2, 5, 2};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_outputs", 64'({rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we}), 64'd0);
    check("rst_buses", 64'({wb_addr, wb_wdata}), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: valid held high, one-cycle-ACK slave, rsp_ready tied high.
    begin
      int unsigned acc = 0, cyc_r = 0, stb_r = 0, ack_n = 0, rsp_n = 0;
      logic prev_cyc = 1'b0, prev_stb = 1'b0;
      req_we = 1'b0;
      req_addr = 16'h0040;
      req_data = 32'h0;
      wb_rdata = 32'h5555_AAAA;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (req_valid && req_ready) acc++;
        if (wb_cyc && !prev_cyc) cyc_r++;
        if (wb_stb && !prev_stb) stb_r++;
        if (rsp_valid) rsp_n++;
        prev_cyc = wb_cyc;
        prev_stb = wb_stb;
        wb_ack = wb_cyc && !wb_stb;
        if (wb_ack) ack_n++;
        @(posedge clk);
        @(negedge clk);
      end
      req_valid = 1'b0;
      wb_ack = 1'b0;
      rsp_ready = 1'b0;
      check("b2b_accepts", 64'(acc), 64'd2);
      check("b2b_cyc_count", 64'(cyc_r), 64'd2);
      check("b2b_stb_count", 64'(stb_r), 64'd2);
      check("b2b_ack_count", 64'(ack_n), 64'd2);
      check("b2b_rsp_count", 64'(rsp_n), 64'd2);
      check("b2b_end_idle", 64'(req_ready), 64'd1);
      check("b2b_last_data", 64'(rsp_data), 64'h5555_AAAA);
    end

    // Reset asserted while waiting for ACK, then a late ACK.
    begin
      int unsigned stray = 0;
      req_we = 1'b0;
      req_addr = 16'h0077;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_in_wait", 64'({wb_cyc, wb_stb}), 64'b10);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_bus_drop", 64'({wb_cyc, wb_stb}), 64'd0);
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      wb_rdata = 32'h7777_7777;
      wb_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        @(negedge clk);
        wb_ack = 1'b0;
        if (rsp_valid || wb_cyc || !req_ready) stray++;
      end
      check("rst_late_ack_ignored", 64'(stray), 64'd0);
    end

`ifdef WB_HOST_TIMEOUT_EN
    begin
      vec_t t;
      t = '{1'b0, 16'h0100, 32'h0, 0, 100, 32'h1357_9BDF, 32'h0, 1'b1, 1, 8, 0};
      run_txn(t, "to_expire");
      t = '{1'b0, 16'h0104, 32'h0, 0, 7, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 1, 8, 0};
      run_txn(t, "to_ack_wins");
      t = '{1'b1, 16'h0108, 32'hFFFF_0000, 50, 0, 32'h0, 32'h0, 1'b1, 8, 8, 1};
      run_txn(t, "to_stalled");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
